// File: rtl/tlul_uart_loader.sv
// UART-driven TL-UL host: parses byte frames into single-word Get/PutFullData
// requests and streams status plus read data back out as bytes.

package tlul_pkg;
   typedef enum logic [2:0] {
      PutFullData    = 3'h0,
      PutPartialData = 3'h1,
      Get            = 3'h4
   } tl_a_op_e;

   typedef enum logic [2:0] {
      AccessAck     = 3'h0,
      AccessAckData = 3'h1
   } tl_d_op_e;

   localparam logic [3:0] MuBi4False = 4'h9;

   typedef struct packed {
      logic [4:0] rsvd;
      logic [3:0] instr_type;
      logic [6:0] cmd_intg;
      logic [6:0] data_intg;
   } tl_a_user_t;

   typedef struct packed {
      logic [6:0] rsp_intg;
      logic [6:0] data_intg;
   } tl_d_user_t;

   typedef struct packed {
      logic        a_valid;
      tl_a_op_e    a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      tl_a_user_t  a_user;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      tl_d_op_e    d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      tl_d_user_t  d_user;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

   // Linear integrity code shared by every host: each payload bit owns a
   // distinct non-zero 7-bit column, check bits are the XOR of set columns.
   function automatic logic [6:0] intg_gen(input logic [56:0] d);
      logic [6:0] c;
      c = '0;
      for (int i = 0; i < 57; i++) begin
         if (d[i]) c ^= 7'(i + 8);
      end
      return c;
   endfunction
endpackage

module tlul_uart_loader
   import tlul_pkg::*;
#(
   parameter logic [7:0]  SourceId      = 8'h00,
   parameter int unsigned TimeoutCycles = 1000000
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          rx_valid_i,
   input  logic [7:0]    rx_data_i,
   output logic          rx_ready_o,
   output logic          tx_valid_o,
   output logic [7:0]    tx_data_o,
   input  logic          tx_ready_i,
   output tlul_pkg::tl_h2d_t tl_o,
   input  tlul_pkg::tl_d2h_t tl_i,
   output logic          busy_o
);
   localparam int unsigned     TmoW    = $clog2(TimeoutCycles);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, REQ, RSP, TX} state_e;

   state_e          state_reg, state_next;
   logic            op_write_reg, op_write_next;
   logic [31:0]     addr_reg, addr_next;
   logic [31:0]     data_reg, data_next;
   logic [1:0]      byte_cnt_reg, byte_cnt_next;
   logic [TmoW-1:0] tmo_cnt_reg, tmo_cnt_next;
   logic [39:0]     resp_reg, resp_next;
   logic [2:0]      resp_len_reg, resp_len_next;
   logic            busy_reg;
   logic            rx_fire;
   logic            in_frame;

   assign in_frame   = (state_reg == ADDR) || (state_reg == DATA);
   assign rx_ready_o = (state_reg == IDLE) || in_frame;
   assign rx_fire    = rx_valid_i && rx_ready_o;
   assign tx_valid_o = (state_reg == TX);
   assign tx_data_o  = tx_valid_o ? resp_reg[7:0] : 8'h00;
   assign busy_o     = busy_reg;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg    <= IDLE;
         op_write_reg <= 1'b0;
         addr_reg     <= '0;
         data_reg     <= '0;
         byte_cnt_reg <= '0;
         tmo_cnt_reg  <= '0;
         resp_reg     <= '0;
         resp_len_reg <= '0;
         busy_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         op_write_reg <= op_write_next;
         addr_reg     <= addr_next;
         data_reg     <= data_next;
         byte_cnt_reg <= byte_cnt_next;
         tmo_cnt_reg  <= tmo_cnt_next;
         resp_reg     <= resp_next;
         resp_len_reg <= resp_len_next;
         busy_reg     <= (state_next != IDLE);
      end
   end

   always_comb begin
      state_next    = state_reg;
      op_write_next = op_write_reg;
      addr_next     = addr_reg;
      data_next     = data_reg;
      byte_cnt_next = byte_cnt_reg;
      resp_next     = resp_reg;
      resp_len_next = resp_len_reg;

      // Idle-gap counter; saturates so a huge gap can never wrap past the limit.
      if (rx_fire || !in_frame) begin
         tmo_cnt_next = '0;
      end else if (tmo_cnt_reg != {TmoW{1'b1}}) begin
         tmo_cnt_next = tmo_cnt_reg + 1'b1;
      end else begin
         tmo_cnt_next = tmo_cnt_reg;
      end

      unique case (state_reg)
         IDLE: begin
            if (rx_fire) begin
               if (rx_data_i == 8'h57 || rx_data_i == 8'h52) begin
                  op_write_next = (rx_data_i == 8'h57);
                  byte_cnt_next = '0;
                  state_next    = ADDR;
               end else begin
                  resp_next     = 40'h3F;
                  resp_len_next = 3'd1;
                  state_next    = TX;
               end
            end
         end
         ADDR: begin
            if (rx_fire) begin
               addr_next     = {rx_data_i, addr_reg[31:8]};
               byte_cnt_next = byte_cnt_reg + 1'b1;
               if (byte_cnt_reg == 2'd3) begin
                  if (addr_next[1:0] != 2'b00) begin
                     resp_next     = 40'h15;
                     resp_len_next = 3'd1;
                     state_next    = TX;
                  end else begin
                     state_next = op_write_reg ? DATA : REQ;
                  end
               end
            end else if (tmo_cnt_reg == TmoLast) begin
               state_next = IDLE;
            end
         end
         DATA: begin
            if (rx_fire) begin
               data_next     = {rx_data_i, data_reg[31:8]};
               byte_cnt_next = byte_cnt_reg + 1'b1;
               if (byte_cnt_reg == 2'd3) state_next = REQ;
            end else if (tmo_cnt_reg == TmoLast) begin
               state_next = IDLE;
            end
         end
         REQ: begin
            if (tl_i.a_ready) state_next = RSP;
         end
         RSP: begin
            if (tl_i.d_valid) begin
               if (tl_i.d_error) begin
                  resp_next     = 40'h15;
                  resp_len_next = 3'd1;
               end else if (op_write_reg) begin
                  resp_next     = 40'h06;
                  resp_len_next = 3'd1;
               end else begin
                  resp_next     = {tl_i.d_data, 8'h06};
                  resp_len_next = 3'd5;
               end
               state_next = TX;
            end
         end
         TX: begin
            if (tx_ready_i) begin
               resp_next     = resp_reg >> 8;
               resp_len_next = resp_len_reg - 1'b1;
               if (resp_len_reg == 3'd1) state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   tl_a_op_e    req_op;
   logic [31:0] req_wdata;

   assign req_op    = op_write_reg ? PutFullData : Get;
   assign req_wdata = op_write_reg ? data_reg : 32'h0;

   // Request fields are only driven in REQ, so they read as zero everywhere else.
   always_comb begin
      tl_o = '0;
      if (state_reg == REQ) begin
         tl_o.a_valid             = 1'b1;
         tl_o.a_opcode            = req_op;
         tl_o.a_size              = 2'd2;
         tl_o.a_source            = SourceId;
         tl_o.a_address           = addr_reg;
         tl_o.a_mask              = 4'hF;
         tl_o.a_data              = req_wdata;
         tl_o.a_user.instr_type   = MuBi4False;
         tl_o.a_user.cmd_intg     = intg_gen(57'({MuBi4False, addr_reg, req_op, 4'hF}));
         tl_o.a_user.data_intg    = intg_gen(57'(req_wdata));
      end
      tl_o.d_ready = (state_reg == RSP);
   end

   logic unused_tl_fields;
   assign unused_tl_fields = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                               tl_i.d_sink, tl_i.d_user};
endmodule

// File: tb/tb_tlul_uart_loader.sv
// Scoreboarded bench for tlul_uart_loader: stimulus queues expected TL requests
// and tx bytes, a device model and a tx monitor pop and compare them.

module tb_tlul_uart_loader;
   import tlul_pkg::*;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          a_wait;
      bit          no_ack;
   } req_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready_o;
   logic        tx_valid_o;
   logic [7:0]  tx_data_o;
   logic        tx_ready;
   tl_h2d_t     tl_o;
   tl_d2h_t     tl_i;
   logic        busy_o;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  tx_q[$];
   req_t        req_q[$];

   always #5 clk = ~clk;

   tlul_uart_loader #(.SourceId(8'h00), .TimeoutCycles(16)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_ready_o(rx_ready_o),
      .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready),
      .tl_o(tl_o), .tl_i(tl_i), .busy_o(busy_o)
   );

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // tx monitor: a byte transfers on the next rising edge when valid&ready here
   always @(negedge clk) begin
      if (tx_valid_o && tx_ready) begin
         if (tx_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_tx: got %h expected no byte", tx_data_o);
         end else begin
            logic [7:0] e;
            e = tx_q.pop_front();
            $display("tx byte %h (expected %h)", tx_data_o, e);
            chk("tx_byte", tx_data_o, e);
         end
      end
   end

   // device model: answers each request after r.a_wait cycles of a_ready=0
   initial begin
      tl_i = '0;
      forever begin
         @(negedge clk);
         if (!tl_o.a_valid) continue;
         if (req_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_req: got addr %h expected no request", tl_o.a_address);
            tl_i.a_ready = 1'b1;
            @(negedge clk);
            tl_i = '0;
            tl_i.d_valid = 1'b1;
            tl_i.d_error = 1'b1;
            @(negedge clk);
            tl_i = '0;
         end else begin
            req_t    r;
            tl_h2d_t cap;
            bit      dropped;
            r = req_q.pop_front();
            cap = tl_o;
            dropped = 1'b0;
            $display("req %s addr=%h data=%h", r.write ? "put" : "get", tl_o.a_address, tl_o.a_data);
            chk("a_opcode", 64'(tl_o.a_opcode), r.write ? 64'h0 : 64'h4);
            chk("a_address", tl_o.a_address, r.addr);
            chk("a_data", tl_o.a_data, r.write ? r.wdata : 32'h0);
            chk("a_mask", tl_o.a_mask, 4'hF);
            chk("a_size", tl_o.a_size, 2'd2);
            chk("a_source", tl_o.a_source, 8'h00);
            chk("a_param", tl_o.a_param, 3'd0);
            chk("instr_type", tl_o.a_user.instr_type, 4'h9);
            chk("d_ready_in_req", tl_o.d_ready, 1'b0);
            for (int w = 1; w <= r.a_wait; w++) begin
               @(negedge clk);
               if (!tl_o.a_valid) begin
                  if (!r.no_ack) chk("a_valid_held", tl_o.a_valid, 1'b1);
                  dropped = 1'b1;
                  break;
               end
               chk("a_stable", (tl_o === cap), 1'b1);
            end
            if (dropped) continue;
            if (r.no_ack) chk("reset_abort_seen", 1'b0, 1'b1);
            tl_i.a_ready = 1'b1;
            @(negedge clk);
            tl_i = '0;
            chk("a_valid_drop", tl_o.a_valid, 1'b0);
            chk("d_ready_in_rsp", tl_o.d_ready, 1'b1);
            tl_i.d_valid  = 1'b1;
            tl_i.d_opcode = r.write ? AccessAck : AccessAckData;
            tl_i.d_data   = r.write ? 32'h0 : r.rdata;
            tl_i.d_error  = r.err;
            @(negedge clk);
            tl_i = '0;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("rx_accept", rx_ready_o, 1'b1);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic push_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input logic err, input int wt, input bit na);
      req_t r;
      r.write = wr; r.addr = a; r.wdata = wd; r.rdata = rd;
      r.err = err; r.a_wait = wt; r.no_ack = na;
      req_q.push_back(r);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((busy_o || tx_q.size() != 0 || req_q.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("reach_idle", {busy_o, (tx_q.size() != 0), (req_q.size() != 0)}, 3'b000);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      rx_valid = 1'b0;
      rx_data = 8'h00;
      tx_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rx_ready", rx_ready_o, 1'b1);
      chk("rst_tx_valid", tx_valid_o, 1'b0);
      chk("rst_tx_data", tx_data_o, 8'h00);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_tl_o", (tl_o === '0), 1'b1);
      rst_n = 1'b1;

      // zero-wait write
      push_req(1'b1, 32'h1000_0000, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 1'b0);
      tx_q.push_back(8'h06);
      send_byte(8'h57); send_word(32'h1000_0000); send_word(32'hDEAD_BEEF);
      wait_idle();

      // read with three stall cycles on a_ready
      push_req(1'b0, 32'h0000_0008, 32'h0, 32'h1234_5678, 1'b0, 3, 1'b0);
      tx_q.push_back(8'h06); tx_q.push_back(8'h78); tx_q.push_back(8'h56);
      tx_q.push_back(8'h34); tx_q.push_back(8'h12);
      send_byte(8'h52); send_word(32'h0000_0008);
      wait_idle();

      // read that errors on the bus
      push_req(1'b0, 32'h0000_0040, 32'h0, 32'hFFFF_FFFF, 1'b1, 1, 1'b0);
      tx_q.push_back(8'h15);
      send_byte(8'h52); send_word(32'h0000_0040);
      wait_idle();

      // misaligned address never reaches the bus
      tx_q.push_back(8'h15);
      send_byte(8'h52); send_word(32'h0000_0002);
      wait_idle();

      // unknown command with tx backpressure
      tx_ready = 1'b0;
      tx_q.push_back(8'h3F);
      send_byte(8'h41);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_tx_valid", tx_valid_o, 1'b1);
         chk("bp_tx_data", tx_data_o, 8'h3F);
         chk("bp_rx_ready", rx_ready_o, 1'b0);
      end
      @(posedge clk);
      #1;
      tx_ready = 1'b1;
      wait_idle();

      // timeout: sixteen idle cycles abort the frame, fifteen do not
      send_byte(8'h57); send_byte(8'h00);
      repeat (15) @(posedge clk);
      @(negedge clk);
      chk("tmo_still_busy", busy_o, 1'b1);
      @(posedge clk);
      @(negedge clk);
      chk("tmo_abort_busy", busy_o, 1'b0);
      chk("tmo_abort_rx_ready", rx_ready_o, 1'b1);
      push_req(1'b0, 32'h0000_0100, 32'h0, 32'hA1B2_C3D4, 1'b0, 0, 1'b0);
      tx_q.push_back(8'h06); tx_q.push_back(8'hD4); tx_q.push_back(8'hC3);
      tx_q.push_back(8'hB2); tx_q.push_back(8'hA1);
      send_byte(8'h52); send_word(32'h0000_0100);
      wait_idle();

      push_req(1'b1, 32'h1000_0000, 32'hCAFE_F00D, 32'h0, 1'b0, 0, 1'b0);
      tx_q.push_back(8'h06);
      send_byte(8'h57); send_byte(8'h00);
      repeat (15) @(posedge clk);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
      send_word(32'hCAFE_F00D);
      wait_idle();

      // reset while the request is pending
      push_req(1'b0, 32'h0000_0020, 32'h0, 32'h0, 1'b0, 50, 1'b1);
      send_byte(8'h52); send_word(32'h0000_0020);
      begin
         int n;
         n = 0;
         while (!tl_o.a_valid && n < 50) begin
            @(negedge clk);
            n++;
         end
      end
      repeat (2) @(negedge clk);
      chk("req_pending", tl_o.a_valid, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_req_a_valid", tl_o.a_valid, 1'b0);
      chk("rst_req_busy", busy_o, 1'b0);
      chk("rst_req_rx_ready", rx_ready_o, 1'b1);
      chk("rst_req_tx_valid", tx_valid_o, 1'b0);
      repeat (3) @(negedge clk);

      push_req(1'b1, 32'h0000_0004, 32'hA5A5_0001, 32'h0, 1'b0, 2, 1'b0);
      tx_q.push_back(8'h06);
      send_byte(8'h57); send_word(32'h0000_0004); send_word(32'hA5A5_0001);
      wait_idle();

      repeat (5) @(negedge clk);
      chk("tx_q_empty", tx_q.size(), 0);
      chk("req_q_empty", req_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
